// File: rtl/sayac_arb_pkg.sv
// Shared types and helpers for the SAYAC 8-way round-robin bus arbiter.
// Index i (0 = d1 ... 7 = d8) always corresponds to select/request bit 7-i.
package sayac_arb_pkg;

  localparam int NUM_REQ = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [2:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[3'd7 - idx] = 1'b1;
    return oh;
  endfunction

  function automatic logic [2:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (oh[k]) idx = 3'(NUM_REQ - 1 - k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating priority encoder: first requesting index at or after
// ptr (mod 8) wins; request bit for index i is req[7-i].
module rr_pick8
  import sayac_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  output logic               any,
  output logic [2:0]         win_idx
);

  logic [2:0] cand;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    any     = 1'b0;
    win_idx = '0;
    cand    = '0;
    // Scan from the far end back toward ptr so the closest hit is the last write.
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      cand = ptr + 3'(j);
      if (req[3'd7 - cand]) begin
        any     = 1'b1;
        win_idx = cand;
      end
    end
  end

endmodule

// File: rtl/sayac_bus_arbiter8.sv
// Round-robin arbiter for the SAYAC shared 16-bit, one-hot-select bus mux, with
// burst limit and optional turnaround gap. Optional urgent mask: SAYAC_ARB_URGENT_EN.
module sayac_bus_arbiter8
  import sayac_arb_pkg::*;
#(
  parameter int MAX_BURST  = 16,
  parameter int TURNAROUND = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
`ifdef SAYAC_ARB_URGENT_EN
  input  logic [NUM_REQ-1:0] urgent,
`endif
  output logic [NUM_REQ-1:0] sel,
  output logic               grant_valid,
  output logic [2:0]         grant_id,
  output logic               handover
);

  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] BURST_LAST = CW'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);

  arb_state_e         state_q, state_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [CW-1:0]      burst_cnt_q, burst_cnt_d;
  logic [NUM_REQ-1:0] sel_q, sel_d;
  logic               grant_valid_q, grant_valid_d;
  logic [2:0]         grant_id_q, grant_id_d;
  logic               handover_q, handover_d;

  logic [NUM_REQ-1:0] arb_req;
  logic [2:0]         pick_ptr;
  logic               pick_any;
  logic [2:0]         pick_idx;
  logic               burst_done;
  logic               release_bus;
  logic               do_arb;
  logic               go_gap;

`ifdef SAYAC_ARB_URGENT_EN
  logic [NUM_REQ-1:0] urgent_req;
  assign urgent_req = req & urgent;
  assign arb_req    = (|urgent_req) ? urgent_req : req;
`else
  assign arb_req = req;
`endif

  // Leaving BUSY searches from the slot after the outgoing owner in the same edge.
  assign pick_ptr    = (state_q == BUSY) ? grant_id_q + 3'd1 : ptr_q;
  assign burst_done  = (MAX_BURST != 0) && (burst_cnt_q == BURST_LAST);
  assign release_bus = !req[3'd7 - grant_id_q] || burst_done;

  rr_pick8 u_pick (
    .req     (arb_req),
    .ptr     (pick_ptr),
    .any     (pick_any),
    .win_idx (pick_idx)
  );

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    burst_cnt_d   = burst_cnt_q;
    sel_d         = sel_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    handover_d    = 1'b0;
    do_arb        = 1'b0;
    go_gap        = 1'b0;

    unique case (state_q)
      BUSY: begin
        if (release_bus) begin
          ptr_d = grant_id_q + 3'd1;
          if (TURNAROUND != 0) go_gap = 1'b1;
          else                 do_arb = 1'b1;
        end else if (burst_cnt_q != '1) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end
      default: do_arb = 1'b1;
    endcase

    if (do_arb && pick_any) begin
      state_d       = BUSY;
      sel_d         = idx_to_onehot(pick_idx);
      grant_valid_d = 1'b1;
      grant_id_d    = pick_idx;
      handover_d    = 1'b1;
      burst_cnt_d   = '0;
    end else if (do_arb || go_gap) begin
      state_d       = go_gap ? GAP : IDLE;
      sel_d         = '0;
      grant_valid_d = 1'b0;
      grant_id_d    = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      burst_cnt_q   <= '0;
      sel_q         <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      handover_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      burst_cnt_q   <= burst_cnt_d;
      sel_q         <= sel_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      handover_q    <= handover_d;
    end
  end

  assign sel         = sel_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign handover    = handover_q;

endmodule

// File: tb/tb_sayac_bus_arbiter8.sv
// Directed bench for sayac_bus_arbiter8: two instances (burst 4 / no gap, burst 3 / gap),
// expected outputs queued as each step is driven and compared after the edge.
module tb_sayac_bus_arbiter8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req_a = '0;
  logic [7:0] req_b = '0;
  logic [7:0] sel_a, sel_b;
  logic       gv_a, gv_b, ho_a, ho_b;
  logic [2:0] id_a, id_b;
`ifdef SAYAC_ARB_URGENT_EN
  logic [7:0] urgent_a = '0;
  logic [7:0] urgent_b = '0;
`endif

  typedef struct packed {
    logic [7:0] sel;
    logic       ho;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sayac_bus_arbiter8 #(.MAX_BURST(4), .TURNAROUND(0)) dut_a (
    .clk         (clk),
    .rst         (rst),
    .req         (req_a),
`ifdef SAYAC_ARB_URGENT_EN
    .urgent      (urgent_a),
`endif
    .sel         (sel_a),
    .grant_valid (gv_a),
    .grant_id    (id_a),
    .handover    (ho_a)
  );

  sayac_bus_arbiter8 #(.MAX_BURST(3), .TURNAROUND(1)) dut_b (
    .clk         (clk),
    .rst         (rst),
    .req         (req_b),
`ifdef SAYAC_ARB_URGENT_EN
    .urgent      (urgent_b),
`endif
    .sel         (sel_b),
    .grant_valid (gv_b),
    .grant_id    (id_b),
    .handover    (ho_b)
  );

  function automatic logic [2:0] expected_id(input logic [7:0] s);
    logic [2:0] id;
    id = '0;
    for (int k = 0; k < 8; k++) begin
      if (s[k]) id = 3'(7 - k);
    end
    return id;
  endfunction

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  // Drive one cycle of stimulus on instance A (on_b=0) or B (on_b=1), then compare.
  task automatic step(input bit on_b, input logic r_rst, input logic [7:0] r,
                      input logic [7:0] e_sel, input logic e_ho, input string tag);
    exp_t e;
    exp_t got;
    logic [7:0] o_sel;
    logic       o_gv, o_ho;
    logic [2:0] o_id;
    rst = r_rst;
    if (on_b) req_b = r;
    else      req_a = r;
    e.sel = e_sel;
    e.ho  = e_ho;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got   = exp_q.pop_front();
    o_sel = on_b ? sel_b : sel_a;
    o_gv  = on_b ? gv_b  : gv_a;
    o_id  = on_b ? id_b  : id_a;
    o_ho  = on_b ? ho_b  : ho_a;
    check({tag, ".sel"},         o_sel,       got.sel);
    check({tag, ".grant_valid"}, {7'd0, o_gv}, {7'd0, (got.sel != 8'h00)});
    check({tag, ".grant_id"},    {5'd0, o_id}, {5'd0, expected_id(got.sel)});
    check({tag, ".handover"},    {7'd0, o_ho}, {7'd0, got.ho});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rot;

    // Reset and idle: nothing granted, no handover.
    step(0, 1'b1, 8'h00, 8'h00, 1'b0, "reset");
    step(0, 1'b1, 8'h00, 8'h00, 1'b0, "reset");
    for (int i = 0; i < 5; i++) step(0, 1'b0, 8'h00, 8'h00, 1'b0, "idle");

    // All requesting, burst 4: every owner holds 4 cycles, full rotation then wrap.
    for (int o = 0; o < 9; o++) begin
      rot = 8'h80 >> (o % 8);
      for (int c = 0; c < 4; c++) step(0, 1'b0, 8'hFF, rot, (c == 0), "rotate");
    end

    // Reset mid-grant with requests present: requests ignored at that edge.
    step(0, 1'b1, 8'hFF, 8'h00, 1'b0, "rst_mid");

    // d1 and d8 request; d1 drops after 2 cycles; d8 then alone hits burst limit.
    step(0, 1'b0, 8'h81, 8'h80, 1'b1, "drop_d1");
    step(0, 1'b0, 8'h81, 8'h80, 1'b0, "drop_d1");
    step(0, 1'b0, 8'h01, 8'h01, 1'b1, "to_d8");
    for (int i = 0; i < 3; i++) step(0, 1'b0, 8'h01, 8'h01, 1'b0, "hold_d8");
    step(0, 1'b0, 8'h01, 8'h01, 1'b1, "regrant_d8");
    step(0, 1'b0, 8'h00, 8'h00, 1'b0, "release_idle");

    // Reset while d4 owns the bus; after release d4 wins again from ptr 0.
    step(0, 1'b0, 8'h11, 8'h10, 1'b1, "d4_first");
    step(0, 1'b0, 8'h11, 8'h10, 1'b0, "d4_hold");
    step(0, 1'b1, 8'h11, 8'h00, 1'b0, "rst_sel10");
    step(0, 1'b0, 8'h11, 8'h10, 1'b1, "d4_wins");

    // d8 withdraws before its turn: d4 is the sole requester and is re-granted.
    for (int i = 0; i < 3; i++) step(0, 1'b0, 8'h10, 8'h10, 1'b0, "d4_only");
    step(0, 1'b0, 8'h10, 8'h10, 1'b1, "withdrawn");
    step(0, 1'b0, 8'h00, 8'h00, 1'b0, "a_idle");

    // Turnaround instance, burst 3, only d2 requesting: 40,40,40,00,...
    step(1, 1'b1, 8'h00, 8'h00, 1'b0, "b_reset");
    for (int i = 0; i < 9; i++) begin
      step(1, 1'b0, 8'h40, (i % 4 == 3) ? 8'h00 : 8'h40, (i % 4 == 0), "gap_burst");
    end
    step(1, 1'b0, 8'h00, 8'h00, 1'b0, "gap_drop");
    step(1, 1'b0, 8'h00, 8'h00, 1'b0, "b_idle");
    // ptr is now 2, so from idle d1 (index 0) wins over d2 only after the wrap.
    step(1, 1'b0, 8'hC0, 8'h80, 1'b1, "b_wrap");
    step(1, 1'b0, 8'h40, 8'h00, 1'b0, "b_gap");
    step(1, 1'b0, 8'h40, 8'h40, 1'b1, "b_after_gap");

`ifdef SAYAC_ARB_URGENT_EN
    // Urgent d7 raised mid-burst: no preemption, then it wins every arbitration.
    urgent_a = 8'h00;
    step(0, 1'b1, 8'h00, 8'h00, 1'b0, "u_reset");
    step(0, 1'b0, 8'hFF, 8'h80, 1'b1, "u_first");
    urgent_a = 8'h02;
    for (int i = 0; i < 3; i++) step(0, 1'b0, 8'hFF, 8'h80, 1'b0, "u_no_preempt");
    step(0, 1'b0, 8'hFF, 8'h02, 1'b1, "u_win");
    for (int i = 0; i < 3; i++) step(0, 1'b0, 8'hFF, 8'h02, 1'b0, "u_hold");
    step(0, 1'b0, 8'hFF, 8'h02, 1'b1, "u_rewin");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
